// File: rtl/i2c_apb_seq.sv
// APB master that runs complete apb_i2c transfers (init, address, data, stop) from one request.
// Each APB access takes a gap, setup and access cycle (plus PREADY waits); write bytes stall on tx_valid, rx has no backpressure.
module i2c_apb_seq #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          LEN_W          = 8,
    parameter logic [15:0] PRESCALE       = 16'h0063
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rnw,
    input  logic [6:0]                req_addr,
    input  logic [LEN_W-1:0]          req_len,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    output logic                      done,
    output logic [1:0]                err,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY
);
    localparam logic [5:0] OFF_PRE  = 6'h00;
    localparam logic [5:0] OFF_CTRL = 6'h04;
    localparam logic [5:0] OFF_RX   = 6'h08;
    localparam logic [5:0] OFF_STAT = 6'h0C;
    localparam logic [5:0] OFF_TX   = 6'h10;
    localparam logic [5:0] OFF_CMD  = 6'h14;

    localparam logic [7:0] CMD_STA  = 8'h80;
    localparam logic [7:0] CMD_STO  = 8'h40;
    localparam logic [7:0] CMD_RD   = 8'h20;
    localparam logic [7:0] CMD_WR   = 8'h10;
    localparam logic [7:0] CMD_ACK  = 8'h08;
    localparam logic [7:0] CMD_IACK = 8'h01;

    localparam logic [1:0] PH_GAP   = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_ACC   = 2'd2;

    localparam logic [1:0] CTX_ADDR = 2'd0;
    localparam logic [1:0] CTX_WR   = 2'd1;
    localparam logic [1:0] CTX_RD   = 2'd2;
    localparam logic [1:0] CTX_STOP = 2'd3;

    typedef enum logic [3:0] {
        S_INIT_PRE, S_INIT_CTRL, S_IDLE, S_ADDR_TX, S_ADDR_CMD, S_POLL, S_IACK,
        S_TXWAIT, S_WR_TX, S_WR_CMD, S_RD_CMD, S_RD_RX, S_STOP, S_DONE
    } state_t;

    state_t           r_state, w_nxt;
    logic [1:0]       r_ph, r_ctx, r_err;
    logic             r_rnw, r_stop, r_al, r_rxack, r_rx_valid;
    logic [6:0]       r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_txb, r_rx_data;

    logic             w_apb_st, w_xfer_done, w_last, w_cnt_zero;
    logic [5:0]       w_off;
    logic [31:0]      w_wdat;
    logic             w_wr;
    logic             w_unused_prdata;

    assign w_unused_prdata = ^PRDATA[31:8];
    assign w_last          = (r_cnt == LEN_W'(1));
    assign w_cnt_zero      = (r_cnt == '0);
    assign w_apb_st        = !(r_state inside {S_IDLE, S_TXWAIT, S_DONE});
    assign w_xfer_done     = w_apb_st && (r_ph == PH_ACC) && PREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_INIT_PRE;
            r_ph       <= PH_GAP;
            r_ctx      <= CTX_ADDR;
            r_err      <= 2'b00;
            r_rnw      <= 1'b0;
            r_stop     <= 1'b0;
            r_al       <= 1'b0;
            r_rxack    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_addr     <= 7'h00;
            r_cnt      <= '0;
            r_txb      <= 8'h00;
            r_rx_data  <= 8'h00;
        end else begin
            r_state    <= w_nxt;
            r_rx_valid <= 1'b0;
            if (w_apb_st) begin
                case (r_ph)
                    PH_GAP:   r_ph <= PH_SETUP;
                    PH_SETUP: r_ph <= PH_ACC;
                    default:  if (PREADY) r_ph <= PH_GAP;
                endcase
            end else begin
                r_ph <= PH_GAP;
            end
            if (r_state == S_IDLE && req_valid) begin
                r_rnw  <= req_rnw;
                r_addr <= req_addr;
                r_cnt  <= req_len;
                r_err  <= 2'b00;
                r_stop <= 1'b0;
            end
            if (r_state == S_TXWAIT && tx_valid) r_txb <= tx_data;
            if (w_xfer_done) begin
                case (r_state)
                    S_ADDR_CMD: begin
                        r_ctx  <= CTX_ADDR;
                        r_stop <= w_cnt_zero;
                    end
                    S_WR_CMD, S_RD_CMD: begin
                        r_ctx  <= (r_state == S_WR_CMD) ? CTX_WR : CTX_RD;
                        r_stop <= w_last;
                        r_cnt  <= r_cnt - LEN_W'(1);
                    end
                    S_STOP: begin
                        r_ctx  <= CTX_STOP;
                        r_stop <= 1'b1;
                    end
                    S_POLL: begin
                        if (PRDATA[0]) begin
                            r_al    <= PRDATA[5];
                            r_rxack <= PRDATA[7];
                        end
                    end
                    S_IACK: begin
                        // rxack only means NACK after the address or a write byte
                        if (r_al) r_err[1] <= 1'b1;
                        else if (r_rxack && (r_ctx == CTX_ADDR || r_ctx == CTX_WR)) r_err[0] <= 1'b1;
                    end
                    S_RD_RX: begin
                        r_rx_data  <= PRDATA[7:0];
                        r_rx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_INIT_PRE:  if (w_xfer_done) w_nxt = S_INIT_CTRL;
            S_INIT_CTRL: if (w_xfer_done) w_nxt = S_IDLE;
            S_IDLE:      if (req_valid) w_nxt = S_ADDR_TX;
            S_ADDR_TX:   if (w_xfer_done) w_nxt = S_ADDR_CMD;
            S_ADDR_CMD:  if (w_xfer_done) w_nxt = S_POLL;
            S_POLL:      if (w_xfer_done && PRDATA[0]) w_nxt = S_IACK;
            S_IACK: begin
                if (w_xfer_done) begin
                    if (r_al) w_nxt = S_DONE;
                    else if (r_ctx == CTX_RD) w_nxt = S_RD_RX;
                    else if (r_ctx == CTX_STOP) w_nxt = S_DONE;
                    else if (r_rxack) w_nxt = r_stop ? S_DONE : S_STOP;
                    else if (w_cnt_zero) w_nxt = S_DONE;
                    else w_nxt = r_rnw ? S_RD_CMD : S_TXWAIT;
                end
            end
            S_TXWAIT:    if (tx_valid) w_nxt = S_WR_TX;
            S_WR_TX:     if (w_xfer_done) w_nxt = S_WR_CMD;
            S_WR_CMD:    if (w_xfer_done) w_nxt = S_POLL;
            S_RD_CMD:    if (w_xfer_done) w_nxt = S_POLL;
            S_RD_RX:     if (w_xfer_done) w_nxt = w_cnt_zero ? S_DONE : S_RD_CMD;
            S_STOP:      if (w_xfer_done) w_nxt = S_POLL;
            S_DONE:      w_nxt = S_IDLE;
            default:     w_nxt = S_INIT_PRE;
        endcase
    end

    always_comb begin
        w_off  = OFF_PRE;
        w_wdat = 32'h0;
        w_wr   = 1'b1;
        case (r_state)
            S_INIT_PRE:  w_wdat = {16'h0, PRESCALE};
            S_INIT_CTRL: begin w_off = OFF_CTRL; w_wdat = 32'h80; end
            S_ADDR_TX:   begin w_off = OFF_TX; w_wdat = {24'h0, r_addr, r_rnw}; end
            S_ADDR_CMD:  begin
                w_off  = OFF_CMD;
                w_wdat = {24'h0, CMD_STA | CMD_WR | (w_cnt_zero ? CMD_STO : 8'h00)};
            end
            S_POLL:      begin w_off = OFF_STAT; w_wr = 1'b0; end
            S_IACK:      begin w_off = OFF_CMD; w_wdat = {24'h0, CMD_IACK}; end
            S_WR_TX:     begin w_off = OFF_TX; w_wdat = {24'h0, r_txb}; end
            S_WR_CMD:    begin
                w_off  = OFF_CMD;
                w_wdat = {24'h0, CMD_WR | (w_last ? CMD_STO : 8'h00)};
            end
            S_RD_CMD:    begin
                w_off  = OFF_CMD;
                w_wdat = {24'h0, CMD_RD | (w_last ? (CMD_STO | CMD_ACK) : 8'h00)};
            end
            S_RD_RX:     begin w_off = OFF_RX; w_wr = 1'b0; end
            S_STOP:      begin w_off = OFF_CMD; w_wdat = {24'h0, CMD_STO}; end
            default:     w_wr = 1'b0;
        endcase

        PSEL      = w_apb_st && (r_ph != PH_GAP);
        PENABLE   = w_apb_st && (r_ph == PH_ACC);
        PADDR     = PSEL ? {{(APB_ADDR_WIDTH-6){1'b0}}, w_off} : '0;
        PWDATA    = (PSEL && w_wr) ? w_wdat : 32'h0;
        PWRITE    = PSEL && w_wr;
        req_ready = (r_state == S_IDLE);
        tx_ready  = (r_state == S_TXWAIT) && tx_valid;
        done      = (r_state == S_DONE);
        err       = (r_state == S_DONE) ? r_err : 2'b00;
        busy      = !(r_state inside {S_INIT_PRE, S_INIT_CTRL, S_IDLE, S_DONE});
        rx_valid  = r_rx_valid;
        rx_data   = r_rx_data;
    end
endmodule

// File: tb/tb_i2c_apb_seq.sv
// Bench for i2c_apb_seq: an apb_i2c slave stand-in with random wait states, a transfer-level model, table and random cases.
`timescale 1ns/1ps
module tb_i2c_apb_seq;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0, req_rnw = 1'b0;
    logic [6:0]  req_addr = 7'h0;
    logic [7:0]  req_len = 8'h0;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_valid = 1'b0;
    logic        req_ready, tx_ready, rx_valid, done, busy;
    logic [7:0]  rx_data;
    logic [1:0]  err;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA = 32'h0;
    logic        PREADY = 1'b0;

    always #5 HCLK = ~HCLK;

    i2c_apb_seq #(.APB_ADDR_WIDTH(12), .LEN_W(8), .PRESCALE(16'h0063)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_len(req_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // apb_i2c stand-in; log entries are {is_read, offset, data}
    logic [38:0] s_log[$];
    logic [7:0]  s_stat_q[$], s_rx_q[$];
    logic [7:0]  s_cur_stat = 8'h0;
    int          s_polls = 0, s_wait = 0, s_viol = 0;
    bit          s_hang = 0;
    logic        prev_psel = 0, prev_pen = 0, prev_rdy = 0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            PREADY = 0; prev_psel = 0; prev_pen = 0; prev_rdy = 0; s_cur_stat = 0;
        end else begin
            if (PENABLE && !PSEL) s_viol++;
            if (PSEL && !prev_psel && PENABLE) s_viol++;
            if (PSEL && prev_psel && !prev_pen && !PENABLE) s_viol++;
            if (prev_pen && prev_rdy && PSEL) s_viol++;
            prev_psel = PSEL; prev_pen = PENABLE; prev_rdy = 0;
            if (PSEL && !PENABLE) begin
                s_wait = $urandom_range(0, 2);
                PREADY = 0;
            end else if (PSEL && PENABLE) begin
                if (s_wait > 0) begin
                    s_wait--; PREADY = 0;
                end else begin
                    PREADY = 1; prev_rdy = 1; PRDATA = 32'h0;
                    if (PWRITE) begin
                        s_log.push_back({1'b0, PADDR[5:0], PWDATA});
                        if (PADDR[5:0] == 6'h14) begin
                            if (PWDATA[7:0] == 8'h01) s_cur_stat = 8'h00;
                            else begin
                                if (s_stat_q.size() > 0) s_cur_stat = s_stat_q.pop_front();
                                else s_cur_stat = 8'h01;
                                s_polls = $urandom_range(0, 2);
                            end
                        end
                    end else if (PADDR[5:0] == 6'h0C) begin
                        if (s_hang || s_polls > 0) begin
                            if (s_polls > 0) s_polls--;
                        end else PRDATA = {24'h0, s_cur_stat};
                    end else if (PADDR[5:0] == 6'h08) begin
                        if (s_rx_q.size() > 0) PRDATA = {24'h0, s_rx_q.pop_front()};
                        else PRDATA = 32'hEE;
                        s_log.push_back({1'b1, 6'h08, PRDATA});
                    end
                end
            end else PREADY = 0;
        end
    end

    // Transfer-level reference: the APB writes/RX reads a transfer must produce, given per-command status bytes
    logic [38:0] m_log[$];
    logic [7:0]  m_rx[$];
    int          m_ntx;
    logic [1:0]  m_err;

    function automatic logic [38:0] wr(input logic [5:0] o, input logic [7:0] d);
        return {1'b0, o, 24'h0, d};
    endfunction
    function automatic logic [7:0] stat_at(input logic [7:0] st[$], input int i);
        return (i < st.size()) ? st[i] : 8'h01;
    endfunction

    task automatic model(input bit rnw, input logic [6:0] a, input int len, input logic [7:0] d[$],
                         input logic [7:0] st[$], input logic [7:0] rx[$]);
        int ci = 1;
        logic [7:0] s;
        bit last;
        m_log.delete(); m_rx.delete(); m_ntx = 0; m_err = 2'b00;
        m_log.push_back(wr(6'h10, {a, rnw}));
        m_log.push_back(wr(6'h14, (len == 0) ? 8'hD0 : 8'h90));
        s = stat_at(st, 0);
        m_log.push_back(wr(6'h14, 8'h01));
        if (s[5]) begin m_err = 2'b10; return; end
        if (s[7]) begin
            m_err = 2'b01;
            if (len != 0) begin m_log.push_back(wr(6'h14, 8'h40)); m_log.push_back(wr(6'h14, 8'h01)); end
            return;
        end
        for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            if (!rnw) begin
                m_ntx++;
                m_log.push_back(wr(6'h10, d[i]));
                m_log.push_back(wr(6'h14, last ? 8'h50 : 8'h10));
            end else begin
                m_log.push_back(wr(6'h14, last ? 8'h68 : 8'h20));
            end
            s = stat_at(st, ci); ci++;
            m_log.push_back(wr(6'h14, 8'h01));
            if (s[5]) begin m_err = 2'b10; return; end
            if (rnw) begin
                m_log.push_back({1'b1, 6'h08, 24'h0, rx[i]});
                m_rx.push_back(rx[i]);
            end else if (s[7]) begin
                m_err = 2'b01;
                if (!last) begin m_log.push_back(wr(6'h14, 8'h40)); m_log.push_back(wr(6'h14, 8'h01)); end
                return;
            end
        end
    endtask

    task automatic run_xfer(input string tag, input bit rnw, input logic [6:0] a, input int len,
                            input logic [7:0] d[$], input logic [7:0] st[$], input logic [7:0] rx[$],
                            output logic [1:0] o_err, output int o_ntx, output int o_nrx, output int o_ncmd);
        int k = 0, cyc = 0;
        bit adv = 0, got_done = 0;
        logic [7:0] rxg[$];
        model(rnw, a, len, d, st, rx);
        s_log.delete(); s_stat_q = st; s_rx_q = rx; s_hang = 0;
        o_err = 2'b11; o_ntx = 0; o_ncmd = 0;
        @(negedge HCLK);
        while (!req_ready && cyc < 200) begin @(negedge HCLK); cyc++; end
        chk({tag, " req_ready"}, req_ready, 1);
        req_valid = 1; req_rnw = rnw; req_addr = a; req_len = len[7:0];
        @(negedge HCLK);
        req_rnw = ~rnw; req_addr = ~a; req_len = 8'hFF;  // ignored while busy
        chk({tag, " busy"}, busy, 1);
        cyc = 0;
        while (!got_done && cyc < 4000) begin
            if (adv) begin k++; adv = 0; end
            tx_valid = (k < len) && ($urandom_range(0, 3) != 0);
            if (k < len) tx_data = d[k];
            else tx_data = 8'($urandom);
            #1;
            if (tx_ready) begin o_ntx++; adv = 1; end
            if (rx_valid) rxg.push_back(rx_data);
            if (done) begin
                got_done = 1; o_err = err; req_valid = 0;
                chk({tag, " busy at done"}, busy, 0);
            end else @(negedge HCLK);
            cyc++;
        end
        tx_valid = 0; req_valid = 0;
        if (!got_done) chk({tag, " done timeout"}, 0, 1);
        @(negedge HCLK); #1;
        chk({tag, " idle after done"}, {req_ready, done, busy}, 3'b100);
        chk({tag, " log size"}, s_log.size(), m_log.size());
        for (int i = 0; i < s_log.size() && i < m_log.size(); i++)
            chk($sformatf("%s log[%0d]", tag, i), s_log[i], m_log[i]);
        foreach (s_log[i]) if (s_log[i][38:32] == 7'h14 && s_log[i][7:0] != 8'h01) o_ncmd++;
        chk({tag, " err"}, o_err, m_err);
        chk({tag, " tx_ready pulses"}, o_ntx, m_ntx);
        chk({tag, " rx count"}, rxg.size(), m_rx.size());
        for (int i = 0; i < rxg.size() && i < m_rx.size(); i++)
            chk($sformatf("%s rx[%0d]", tag, i), rxg[i], m_rx[i]);
        o_nrx = rxg.size();
    endtask

    typedef struct {
        bit         rnw;
        logic [6:0] addr;
        int         len;
        logic [7:0] b0, b1, b2;
        int         fail_idx;
        logic [7:0] fail_st;
        logic [1:0] exp_err;
        int         exp_tx, exp_rx, exp_ncmd;
    } vec_t;

    function automatic vec_t mkv(input bit rnw, input logic [6:0] a, input int len,
                                 input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                 input int fi, input logic [7:0] fs, input logic [1:0] e,
                                 input int ntx, input int nrx, input int ncmd);
        vec_t v;
        v.rnw = rnw; v.addr = a; v.len = len; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.fail_idx = fi; v.fail_st = fs; v.exp_err = e;
        v.exp_tx = ntx; v.exp_rx = nrx; v.exp_ncmd = ncmd;
        return v;
    endfunction

    vec_t        tv[8];
    logic [7:0]  dq[$], sq[$], rq[$];
    logic [1:0]  g_err;
    int          g_ntx, g_nrx, g_ncmd, cyc;

    initial begin
        tv[0] = mkv(0, 7'h50, 2, 8'hA5, 8'h3C, 8'h00, -1, 8'h01, 2'b00, 2, 0, 3);
        tv[1] = mkv(1, 7'h50, 3, 8'h11, 8'h22, 8'h33, -1, 8'h01, 2'b00, 0, 3, 4);
        tv[2] = mkv(0, 7'h2A, 0, 8'h00, 8'h00, 8'h00,  0, 8'h81, 2'b01, 0, 0, 1);
        tv[3] = mkv(0, 7'h50, 3, 8'h01, 8'h02, 8'h03,  1, 8'h81, 2'b01, 1, 0, 3);
        tv[4] = mkv(0, 7'h50, 2, 8'h77, 8'h88, 8'h00,  0, 8'h21, 2'b10, 0, 0, 1);
        tv[5] = mkv(0, 7'h13, 1, 8'hC3, 8'h00, 8'h00,  1, 8'h81, 2'b01, 1, 0, 2);
        tv[6] = mkv(1, 7'h7F, 2, 8'h5A, 8'hA5, 8'h00,  1, 8'h81, 2'b00, 0, 2, 3);
        tv[7] = mkv(1, 7'h01, 2, 8'h44, 8'h55, 8'h00,  1, 8'h21, 2'b10, 0, 0, 2);

        #1;
        chk("reset outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, tx_ready,
                              rx_valid, rx_data, done, err, busy}, '0);
        repeat (3) @(negedge HCLK);
        s_log.delete();
        HRESETn = 1;
        cyc = 0;
        while (!req_ready && cyc < 100) begin @(negedge HCLK); cyc++; end
        chk("init req_ready", req_ready, 1);
        repeat (5) @(negedge HCLK);
        chk("init log size", s_log.size(), 2);
        if (s_log.size() == 2) begin
            chk("init PRE", s_log[0], {1'b0, 6'h00, 32'h0063});
            chk("init CTRL", s_log[1], {1'b0, 6'h04, 32'h0080});
        end
        chk("init idle busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            dq.delete(); sq.delete(); rq.delete();
            for (int j = 0; j < tv[i].len; j++) begin
                logic [7:0] b;
                b = (j == 0) ? tv[i].b0 : (j == 1) ? tv[i].b1 : tv[i].b2;
                dq.push_back(b); rq.push_back(b);
            end
            for (int j = 0; j < tv[i].len + 2; j++)
                sq.push_back((j == tv[i].fail_idx) ? tv[i].fail_st : 8'h01);
            run_xfer($sformatf("vec%0d", i), tv[i].rnw, tv[i].addr, tv[i].len, dq, sq, rq,
                     g_err, g_ntx, g_nrx, g_ncmd);
            chk($sformatf("vec%0d tbl err", i), g_err, tv[i].exp_err);
            chk($sformatf("vec%0d tbl tx", i), g_ntx, tv[i].exp_tx);
            chk($sformatf("vec%0d tbl rx", i), g_nrx, tv[i].exp_rx);
            chk($sformatf("vec%0d tbl cmds", i), g_ncmd, tv[i].exp_ncmd);
        end

        for (int t = 0; t < 25; t++) begin
            bit rnw;
            int len, ft, fi;
            logic [7:0] v;
            rnw = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 4);
            ft = $urandom_range(0, 3);
            fi = $urandom_range(0, len);
            dq.delete(); sq.delete(); rq.delete();
            for (int j = 0; j < len; j++) begin
                dq.push_back(8'($urandom)); rq.push_back(8'($urandom));
            end
            for (int j = 0; j < len + 2; j++) begin
                v = 8'h01;
                if (rnw && j > 0 && $urandom_range(0, 1) == 1) v = 8'h81;
                if (ft >= 2 && j > fi) v = 8'h01;
                if (ft == 2 && j == fi) v = 8'h81;
                if (ft == 3 && j == fi) v = 8'h21;
                sq.push_back(v);
            end
            run_xfer($sformatf("rnd%0d", t), rnw, 7'($urandom), len, dq, sq, rq,
                     g_err, g_ntx, g_nrx, g_ncmd);
        end

        // reset while polling STATUS: APB must drop at once and init must re-run
        s_hang = 1; s_stat_q.delete(); s_log.delete();
        @(negedge HCLK);
        req_valid = 1; req_rnw = 0; req_addr = 7'h33; req_len = 8'h00;
        @(negedge HCLK);
        req_valid = 0;
        cyc = 0;
        while (!(PSEL && PENABLE && PADDR[5:0] == 6'h0C && cyc > 10) && cyc < 300) begin
            @(negedge HCLK); cyc++;
        end
        chk("midpoll in STATUS access", {PSEL, PENABLE, PADDR[5:0]}, {2'b11, 6'h0C});
        #2 HRESETn = 0;
        #1;
        chk("midpoll reset APB drop", {PSEL, PENABLE, busy, req_ready}, 4'b0000);
        @(negedge HCLK);
        s_hang = 0; s_log.delete();
        HRESETn = 1;
        cyc = 0;
        while (!req_ready && cyc < 100) begin @(negedge HCLK); cyc++; end
        chk("reinit req_ready", req_ready, 1);
        chk("reinit log size", s_log.size(), 2);
        if (s_log.size() == 2) begin
            chk("reinit PRE", s_log[0], {1'b0, 6'h00, 32'h0063});
            chk("reinit CTRL", s_log[1], {1'b0, 6'h04, 32'h0080});
        end

        chk("apb protocol violations", s_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
